ram_sync: RTL and testbench

Parametrised, synchronous-read successor to the CPU's main RAM. After reset it runs a one-word-per-cycle initialisation pass that loads a fixed boot program, or zero-fills the array. It then serves read, write and read-then-write (swap) commands from the control unit's 2-bit control word. It sits on the external address/data bus between the CPU datapath (`eab`, `din`) and the data-bus return (`edb`), and adds a ready flag and an error pulse.

---
 rtl/ram_sync_if.sv | 17 +
 rtl/ram_sync.sv | 149 ++++++++++++++
 tb/tb_ram_sync.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_if.sv
// ram_sync_if: command/address/data bus between the CPU datapath and ram_sync.
// The master drives the command word, address and write data; the slave
// returns registered read data plus the ready and error flags.
interface ram_sync_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [1:0]        cword;
   logic [ADDR_W-1:0] eab;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] edb;
   logic              rdy;
   logic              err;

   modport master (output cword, eab, din, input edb, rdy, err);
   modport slave  (input cword, eab, din, output edb, rdy, err);
endinterface

// File: rtl/ram_sync.sv
// ram_sync: synchronous-read word RAM with a post-reset initialisation pass.
// After reset it writes one word per cycle (INIT), then serves nop / write /
// read / swap commands (RUN). Read data is registered (1-cycle latency).
// Optional feature macro: RAM_SYNC_BOOT_EN -- when defined, INIT loads the
// boot program into words 0..9 instead of zero-filling them.
// DEPTH must lie in 16..2**ADDR_W; the interface widths must match DATA_W/ADDR_W.
module ram_sync #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic       clk2,
   input  logic       reset,
   ram_sync_if.slave  bus
);

   typedef enum logic {ST_INIT, ST_RUN} state_e;
   typedef enum logic [1:0] {
      CMD_NOP   = 2'b00,
      CMD_WRITE = 2'b01,
      CMD_READ  = 2'b10,
      CMD_SWAP  = 2'b11
   } cmd_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] icnt_q, icnt_d;
   logic [DATA_W-1:0] edb_q, edb_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] init_word;
   logic              addr_ok;
   cmd_e              cmd;

   assign cmd     = cmd_e'(bus.cword);
   assign addr_ok = (32'(bus.eab) < DEPTH);
   assign rd_data = mem[bus.eab];

`ifdef RAM_SYNC_BOOT_EN
   // Boot program image, zero-extended to the word width; all other words are 0.
   function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] a);
      logic [7:0] b;
      b = 8'h00;
      case (a)
         ADDR_W'(0): b = 8'hC4;
         ADDR_W'(1): b = 8'h06;
         ADDR_W'(2): b = 8'h05;
         ADDR_W'(3): b = 8'h56;
         ADDR_W'(4): b = 8'hA4;
         ADDR_W'(5): b = 8'h0B;
         ADDR_W'(6): b = 8'h0C;
         ADDR_W'(7): b = 8'h03;
         ADDR_W'(8): b = 8'h00;
         ADDR_W'(9): b = 8'h02;
         default:    b = 8'h00;
      endcase
      return DATA_W'(b);
   endfunction

   assign init_word = boot_word(icnt_q);
`else
   assign init_word = '0;
`endif

   // Next-state, output and array-port decode for the INIT/RUN machine.
   // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      icnt_d    = icnt_q;
      edb_d     = edb_q;
      rdy_d     = rdy_q;
      err_d     = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = bus.eab;
      mem_wdata = bus.din;

      case (state_q)
         ST_INIT: begin
            // Commands are ignored while initialising; anything but nop is flagged.
            mem_we    = 1'b1;
            mem_addr  = icnt_q;
            mem_wdata = init_word;
            err_d     = (cmd != CMD_NOP);
            if (icnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
               rdy_d   = 1'b1;
            end else begin
               icnt_d = icnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            case (cmd)
               CMD_WRITE: begin
                  mem_we = addr_ok;
                  err_d  = !addr_ok;
               end
               CMD_READ: begin
                  edb_d = addr_ok ? rd_data : '0;
                  err_d = !addr_ok;
               end
               CMD_SWAP: begin
                  // Old word goes to edb while the new one is written on the same edge.
                  edb_d  = addr_ok ? rd_data : '0;
                  mem_we = addr_ok;
                  err_d  = !addr_ok;
               end
               default: ;
            endcase
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Control and output registers; reset forces INIT and clears the counter.
   // NOTE: sequential state uses nonblocking assignments so all registers update together.
   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         state_q <= ST_INIT;
         icnt_q  <= '0;
         edb_q   <= '0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         icnt_q  <= icnt_d;
         edb_q   <= edb_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
      end
   end

   // Array write port.
   // NOTE: the array has no reset; the INIT pass rewrites every word after each reset.
   always_ff @(posedge clk2) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   assign bus.edb = edb_q;
   assign bus.rdy = rdy_q;
   assign bus.err = err_q;

endmodule

// File: tb/tb_ram_sync.sv
// tb_ram_sync: scoreboard bench for ram_sync. Two instances share clock and
// reset: A (DEPTH=256) and B (DEPTH=200, for out-of-range addresses).
// Stimulus pushes the expected outputs for the next edge into a queue; a
// monitor on the falling edge pops and compares them.
module tb_ram_sync;

   localparam int DW = 8;
   localparam int AW = 8;

   typedef struct {
      string      name;
      int         cyc;
      int         dut;
      logic [7:0] edb;
      logic       err;
      logic       rdy;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];
   logic [7:0] exp_boot [11];

   ram_sync_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
   ram_sync_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

   ram_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) dut_a (
      .clk2  (clk),
      .reset (rst_n),
      .bus   (ifa.slave)
   );

   ram_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200)) dut_b (
      .clk2  (clk),
      .reset (rst_n),
      .bus   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation scheduled for the edge just passed.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t       e;
         logic [7:0] a_edb;
         logic       a_err;
         logic       a_rdy;
         e = sb.pop_front();
         if (e.dut == 0) begin
            a_edb = ifa.edb; a_err = ifa.err; a_rdy = ifa.rdy;
         end else begin
            a_edb = ifb.edb; a_err = ifb.err; a_rdy = ifb.rdy;
         end
         n_tests++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s dut%0d: checked at cycle %0d, required cycle %0d", e.name, e.dut, cyc, e.cyc);
         end else if (a_edb !== e.edb || a_err !== e.err || a_rdy !== e.rdy) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: edb=%h err=%b rdy=%b, required edb=%h err=%b rdy=%b",
                     e.name, e.dut, cyc, a_edb, a_err, a_rdy, e.edb, e.err, e.rdy);
         end
      end
   end

   // Schedule an expectation for the outputs after the next rising edge.
   task automatic chk(input string name, input int dut, input logic [7:0] edb,
                      input logic err, input logic rdy);
      exp_t e;
      e.name = name;
      e.cyc  = cyc + 1;
      e.dut  = dut;
      e.edb  = edb;
      e.err  = err;
      e.rdy  = rdy;
      sb.push_back(e);
   endtask

   task automatic set_in(input logic [1:0] ca, input logic [7:0] aa, input logic [7:0] da,
                         input logic [1:0] cb, input logic [7:0] ab, input logic [7:0] db);
      ifa.cword = ca; ifa.eab = aa; ifa.din = da;
      ifb.cword = cb; ifb.eab = ab; ifb.din = db;
   endtask

   // Apply one cycle of commands to both instances, return at the next falling edge.
   task automatic step(input logic [1:0] ca, input logic [7:0] aa, input logic [7:0] da,
                       input logic [1:0] cb, input logic [7:0] ab, input logic [7:0] db);
      set_in(ca, aa, da, cb, ab, db);
      @(negedge clk);
   endtask

   // Run nops through the INIT pass, checking the exact rdy rise of both instances.
   task automatic run_init(input int rel, input string tag);
      while (cyc < rel + 256) begin
         if (cyc + 1 == rel + 199) chk({tag, "_b_rdy_low"}, 1, 8'h00, 1'b0, 1'b0);
         if (cyc + 1 == rel + 200) chk({tag, "_b_rdy_rise"}, 1, 8'h00, 1'b0, 1'b1);
         if (cyc + 1 == rel + 255) chk({tag, "_a_rdy_low"}, 0, 8'h00, 1'b0, 1'b0);
         if (cyc + 1 == rel + 256) chk({tag, "_a_rdy_rise"}, 0, 8'h00, 1'b0, 1'b1);
         step(2'b00, 8'd0, 8'd0, 2'b00, 8'd0, 8'd0);
      end
   endtask

   localparam logic [1:0] NOP = 2'b00, WR = 2'b01, RD = 2'b10, SW = 2'b11;

   initial begin
      int rel;
      n_tests = 0;
      n_fail  = 0;
`ifdef RAM_SYNC_BOOT_EN
      exp_boot = '{8'hC4, 8'h06, 8'h05, 8'h56, 8'hA4, 8'h0B, 8'h0C, 8'h03, 8'h00, 8'h02, 8'h00};
`else
      exp_boot = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
      rst_n = 1'b0;
      set_in(NOP, 8'd0, 8'd0, NOP, 8'd0, 8'd0);
      @(negedge clk);
      @(negedge clk);

      // Reset state, with a command applied while reset is held.
      chk("reset_a", 0, 8'h00, 1'b0, 1'b0);
      chk("reset_b", 1, 8'h00, 1'b0, 1'b0);
      step(RD, 8'd3, 8'd0, WR, 8'd3, 8'hFF);

      // Release reset; a read during INIT is rejected with a one-cycle err pulse.
      rst_n = 1'b1;
      rel = cyc;
      chk("init_read_err", 0, 8'h00, 1'b1, 1'b0);
      chk("init_nop_b", 1, 8'h00, 1'b0, 1'b0);
      step(RD, 8'd0, 8'd0, NOP, 8'd0, 8'd0);
      chk("init_err_drop", 0, 8'h00, 1'b0, 1'b0);
      step(NOP, 8'd0, 8'd0, NOP, 8'd0, 8'd0);
      run_init(rel, "init1");

      // Contents loaded by INIT at words 0..10.
      for (int i = 0; i <= 10; i++) begin
         chk($sformatf("init_rd_%0d", i), 0, exp_boot[i], 1'b0, 1'b1);
         step(RD, 8'(i), 8'd0, NOP, 8'd0, 8'd0);
      end

      // Write then read back; nops hold edb. B exercises out-of-range addresses.
      chk("wr20_hold", 0, exp_boot[10], 1'b0, 1'b1);
      chk("b_wr5", 1, 8'h00, 1'b0, 1'b1);
      step(WR, 8'd20, 8'h5A, WR, 8'd5, 8'h33);
      chk("rd20", 0, 8'h5A, 1'b0, 1'b1);
      chk("b_rd5", 1, 8'h33, 1'b0, 1'b1);
      step(RD, 8'd20, 8'd0, RD, 8'd5, 8'd0);
      chk("nop_hold1", 0, 8'h5A, 1'b0, 1'b1);
      chk("b_wr210_err", 1, 8'h33, 1'b1, 1'b1);
      step(NOP, 8'd0, 8'd0, WR, 8'd210, 8'h99);
      chk("nop_hold2", 0, 8'h5A, 1'b0, 1'b1);
      chk("b_rd210_err", 1, 8'h00, 1'b1, 1'b1);
      step(NOP, 8'd0, 8'd0, RD, 8'd210, 8'd0);

      // Swap returns the old word and stores the new one.
      chk("swap9_old", 0, exp_boot[9], 1'b0, 1'b1);
      chk("b_err_clear", 1, 8'h00, 1'b0, 1'b1);
      step(SW, 8'd9, 8'h77, NOP, 8'd0, 8'd0);
      chk("rd9_new", 0, 8'h77, 1'b0, 1'b1);
      chk("b_rd199", 1, 8'h00, 1'b0, 1'b1);
      step(RD, 8'd9, 8'd0, RD, 8'd199, 8'd0);
      chk("nop_hold3", 0, 8'h77, 1'b0, 1'b1);
      chk("b_wr199", 1, 8'h00, 1'b0, 1'b1);
      step(NOP, 8'd0, 8'd0, WR, 8'd199, 8'h44);
      chk("swap10_old", 0, 8'h00, 1'b0, 1'b1);
      chk("b_rd199_new", 1, 8'h44, 1'b0, 1'b1);
      step(SW, 8'd10, 8'h12, RD, 8'd199, 8'd0);
      chk("rd10_new", 0, 8'h12, 1'b0, 1'b1);
      chk("b_rd200_err", 1, 8'h00, 1'b1, 1'b1);
      step(RD, 8'd10, 8'd0, RD, 8'd200, 8'd0);
      chk("swap255_old", 0, 8'h00, 1'b0, 1'b1);
      chk("b_err_clear2", 1, 8'h00, 1'b0, 1'b1);
      step(SW, 8'd255, 8'h3C, NOP, 8'd0, 8'd0);
      chk("rd255_new", 0, 8'h3C, 1'b0, 1'b1);
      step(RD, 8'd255, 8'd0, NOP, 8'd0, 8'd0);

      // Reset asserted in the middle of a write stream.
      chk("midrst_a", 0, 8'h00, 1'b0, 1'b0);
      chk("midrst_b", 1, 8'h00, 1'b0, 1'b0);
      set_in(WR, 8'd30, 8'h11, WR, 8'd6, 8'h22);
      #2 rst_n = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_hold_a", 0, 8'h00, 1'b0, 1'b0);
         step(WR, 8'd20, 8'h66, WR, 8'd7, 8'h55);
      end
      rst_n = 1'b1;
      rel = cyc;
      run_init(rel, "init2");

      // Earlier writes are gone after the second INIT pass.
      chk("post_rd20", 0, 8'h00, 1'b0, 1'b1);
      chk("post_b_rd6", 1, 8'h00, 1'b0, 1'b1);
      step(RD, 8'd20, 8'd0, RD, 8'd6, 8'd0);
      chk("post_rd0", 0, exp_boot[0], 1'b0, 1'b1);
      chk("post_b_rd199", 1, 8'h00, 1'b0, 1'b1);
      step(RD, 8'd0, 8'd0, RD, 8'd199, 8'd0);
      chk("post_rd30", 0, 8'h00, 1'b0, 1'b1);
      step(RD, 8'd30, 8'd0, NOP, 8'd0, 8'd0);
      chk("post_rd9", 0, exp_boot[9], 1'b0, 1'b1);
      step(RD, 8'd9, 8'd0, NOP, 8'd0, 8'd0);

      // Drain and make sure nothing was left unchecked.
      step(NOP, 8'd0, 8'd0, NOP, 8'd0, 8'd0);
      @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
